// File: rtl/rsa_key_builder.sv
// rtl/rsa_key_builder.sv - RSA key builder: N=P*Q, D=E^-1 mod (P-1)(Q-1)
// The multiplier is shift-add and the divider is restoring; both are sequential.
module rsa_key_builder #(
    parameter int unsigned WORD_WIDTH = 32,
    parameter int unsigned E_VALUE    = 65537
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [WORD_WIDTH/2-1:0] P,
    input  logic [WORD_WIDTH/2-1:0] Q,
    output logic                    busy,
    output logic                    done,
    output logic                    error,
    output logic [WORD_WIDTH-1:0]   N,
    output logic [WORD_WIDTH-1:0]   E,
    output logic [WORD_WIDTH-1:0]   D
);
    localparam int W  = WORD_WIDTH;
    localparam int H  = WORD_WIDTH / 2;
    localparam int CW = $clog2(W);
    localparam logic [W-1:0]  E_W      = W'(E_VALUE);
    localparam logic [W-1:0]  ONE_W    = W'(1);
    localparam logic [H-1:0]  ONE_H    = H'(1);
    localparam logic [H-1:0]  THREE_H  = H'(3);
    localparam logic [CW-1:0] ONE_C    = CW'(1);
    localparam logic [CW-1:0] MUL_LAST = CW'(H - 1);
    localparam logic [CW-1:0] DIV_LAST = CW'(W - 1);

    typedef enum logic [2:0] {IDLE, LOAD, MUL, DIV, UPD, FIX, DONE} state_t;

    state_t             state;
    logic [H-1:0]       p_r, q_r, mp_n, mp_phi;
    logic [W-1:0]       mc_n, mc_phi, phi, r0, r1, dq, rm;
    logic signed [W:0]  t0, t1;
    logic [CW-1:0]      cnt;

    logic [W-1:0]       n_sum, phi_sum, rm_nx, dq_nx, t_pos;
    logic [W:0]         rm_sh, qt, t_new;
    logic               sub_ok;

    assign E = E_W;

    always_comb begin
        n_sum   = N   + (mp_n[0]   ? mc_n   : '0);
        phi_sum = phi + (mp_phi[0] ? mc_phi : '0);
        rm_sh   = {rm, dq[W-1]};
        sub_ok  = rm_sh >= {1'b0, r1};
        rm_nx   = sub_ok ? (rm_sh[W-1:0] - r1) : rm_sh[W-1:0];
        dq_nx   = {dq[W-2:0], sub_ok};
        // Only the low W+1 bits of q*t1 matter: the true t stays within +/-phi.
        qt      = {1'b0, dq} * t1;
        t_new   = t0 - qt;
        t_pos   = t0[W-1:0] + phi;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            error  <= 1'b0;
            N      <= '0;
            D      <= '0;
            p_r    <= '0;
            q_r    <= '0;
            mp_n   <= '0;
            mp_phi <= '0;
            mc_n   <= '0;
            mc_phi <= '0;
            phi    <= '0;
            r0     <= '0;
            r1     <= '0;
            dq     <= '0;
            rm     <= '0;
            t0     <= '0;
            t1     <= '0;
            cnt    <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        p_r   <= P;
                        q_r   <= Q;
                        done  <= 1'b0;
                        error <= 1'b0;
                        busy  <= 1'b1;
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    if (p_r == q_r || !p_r[0] || !q_r[0] || p_r < THREE_H || q_r < THREE_H) begin
                        error <= 1'b1;
                        N     <= '0;
                        D     <= '0;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= DONE;
                    end else begin
                        N      <= '0;
                        phi    <= '0;
                        mc_n   <= {{H{1'b0}}, p_r};
                        mc_phi <= {{H{1'b0}}, p_r - ONE_H};
                        mp_n   <= q_r;
                        mp_phi <= q_r - ONE_H;
                        cnt    <= '0;
                        state  <= MUL;
                    end
                end
                MUL: begin
                    N      <= n_sum;
                    phi    <= phi_sum;
                    mc_n   <= mc_n << 1;
                    mc_phi <= mc_phi << 1;
                    mp_n   <= mp_n >> 1;
                    mp_phi <= mp_phi >> 1;
                    cnt    <= cnt + ONE_C;
                    if (cnt == MUL_LAST) begin
                        // Seeding (E,phi) with t=(1,0) makes the first Euclid step
                        // produce (phi, E mod phi) with t=(0,1).
                        r0    <= E_W;
                        r1    <= phi_sum;
                        t0    <= {{W{1'b0}}, 1'b1};
                        t1    <= '0;
                        dq    <= E_W;
                        rm    <= '0;
                        cnt   <= '0;
                        state <= DIV;
                    end
                end
                DIV: begin
                    dq  <= dq_nx;
                    rm  <= rm_nx;
                    cnt <= cnt + ONE_C;
                    if (cnt == DIV_LAST)
                        state <= UPD;
                end
                UPD: begin
                    r0 <= r1;
                    r1 <= rm;
                    t0 <= t1;
                    t1 <= t_new;
                    if (rm == '0) begin
                        state <= FIX;
                    end else begin
                        dq    <= r1;
                        rm    <= '0;
                        cnt   <= '0;
                        state <= DIV;
                    end
                end
                FIX: begin
                    if (r0 != ONE_W) begin
                        error <= 1'b1;
                        D     <= '0;
                    end else begin
                        D <= t0[W] ? t_pos : t0[W-1:0];
                    end
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_rsa_key_builder.sv
// tb/tb_rsa_key_builder.sv - directed bench for rsa_key_builder
module tb_rsa_key_builder;
    logic        clk = 1'b0;
    logic        rst, start, start3;
    logic [15:0] P, Q;
    logic [7:0]  P3, Q3;
    logic        busy, done, error, busy3, done3, error3;
    logic [31:0] N, E, D;
    logic [15:0] N3, E3, D3;
    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc;
    logic [63:0] dd;

    rsa_key_builder #(.WORD_WIDTH(32), .E_VALUE(65537)) dut (
        .clk(clk), .rst(rst), .start(start), .P(P), .Q(Q),
        .busy(busy), .done(done), .error(error), .N(N), .E(E), .D(D)
    );

    rsa_key_builder #(.WORD_WIDTH(16), .E_VALUE(3)) dut3 (
        .clk(clk), .rst(rst), .start(start3), .P(P3), .Q(Q3),
        .busy(busy3), .done(done3), .error(error3), .N(N3), .E(E3), .D(D3)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic go(input logic [15:0] p, input logic [15:0] q);
        @(negedge clk);
        P = p;
        Q = q;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        for (int i = 0; i < 2200 && !done; i++)
            @(negedge clk);
        chk(tag, done, 1);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; start3 = 1'b0;
        P = '0; Q = '0; P3 = '0; Q3 = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        chk("rst_n", N, 0);
        chk("rst_d", D, 0);
        chk("rst_e", E, 65537);
        chk("rst_e3", E3, 3);
        rst = 1'b0;

        go(61, 53);
        chk("small_busy", busy, 1);
        wait_done("small_done");
        chk("small_err", error, 0);
        chk("small_n", N, 3233);
        chk("small_d", D, 2753);
        chk("small_busy_lo", busy, 0);
        repeat (3) @(negedge clk);
        chk("small_hold_d", D, 2753);
        chk("small_hold_done", done, 1);

        @(negedge clk);
        P = 61; Q = 61; start = 1'b1;
        cyc = 0;
        do begin
            @(negedge clk);
            start = 1'b0;
            cyc++;
        end while (!error && cyc < 3);
        chk("eq_err", error, 1);
        chk("eq_n", N, 0);
        chk("eq_d", D, 0);

        @(negedge clk);
        P = 60; Q = 53; start = 1'b1;
        cyc = 0;
        do begin
            @(negedge clk);
            start = 1'b0;
            cyc++;
        end while (!error && cyc < 3);
        chk("even_err", error, 1);
        chk("even_done", done, 1);

        go(65521, 65531);
        wait_done("fw_done");
        chk("fw_n", N, 64'd4293656651);
        chk("fw_err", error, 0);
        dd = {32'd0, D};
        chk("fw_inv", (dd * 64'd65537) % 64'd4293525600, 1);
        chk("fw_range", (dd != 0 && dd < 64'd4293525600), 1);

        go(61, 53);
        repeat (3) @(negedge clk);
        P = 3; Q = 11; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (30) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("ign_done");
        chk("ign_n", N, 3233);
        chk("ign_d", D, 2753);

        go(3, 11);
        chk("b2b_drop", done, 0);
        wait_done("b2b_done");
        chk("b2b_n", N, 33);
        chk("b2b_d", D, 13);
        chk("b2b_err", error, 0);

        go(61, 53);
        repeat (20) @(negedge clk);
        chk("middiv_busy", busy, 1);
        chk("middiv_n", N, 3233);
        rst = 1'b1;
        @(negedge clk);
        chk("middiv_rst_busy", busy, 0);
        chk("middiv_rst_done", done, 0);
        chk("middiv_rst_n", N, 0);
        chk("middiv_rst_d", D, 0);

        start = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        start = 1'b0;
        chk("prio_busy", busy, 0);
        @(negedge clk);
        chk("prio_busy2", busy, 0);

        go(61, 53);
        wait_done("after_rst_done");
        chk("after_rst_d", D, 2753);
        chk("after_rst_n", N, 3233);

        @(negedge clk);
        P3 = 7; Q3 = 11; start3 = 1'b1;
        @(negedge clk);
        start3 = 1'b0;
        for (int i = 0; i < 600 && !done3; i++)
            @(negedge clk);
        chk("e3_done", done3, 1);
        chk("e3_err", error3, 1);
        chk("e3_d", D3, 0);
        chk("e3_n", N3, 77);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
